// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and defaults for the data_memory bus arbiter.
//   arb_state_e : FSM state encoding (IDLE/ACCESS/WAIT/RESPOND, 2 bits)
//   arb_op_t    : operation latched with the grant
//   grant_width : index width for a channel count, never below 1
package data_bus_arbiter_pkg;

  localparam int DEF_ADDRESS_SIZE = 16;
  localparam int DEF_DATA_SIZE    = 16;
  localparam int DEF_MEM_LATENCY  = 1;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ACCESS  = 2'd1,
    ARB_WAIT    = 2'd2,
    ARB_RESPOND = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic write;     // write wins when read and write are both set
    logic conflict;  // granted channel had read and write both set
  } arb_op_t;

  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_bus_arbiter_round_robin_picker.sv
// Combinational round-robin winner selection.
//   req        : per-channel request vector
//   last_grant : index of the previous winner
//   winner     : first requesting channel at or after last_grant+1, wrapping
//   valid      : at least one channel is requesting
module round_robin_picker #(
  parameter int CHANNELS = 2,
  parameter int GW       = 1
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [GW-1:0]       last_grant,
  output logic [GW-1:0]       winner,
  output logic                valid
);

  // Walk from farthest to nearest so the nearest requester is the last write.
  always_comb begin
    winner = '0;
    valid  = |req;
    for (int i = CHANNELS; i >= 1; i--) begin
      int idx;
      idx = int'(last_grant) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (req[idx]) winner = GW'(idx);
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing one data_memory port among CHANNELS masters.
// One transaction outstanding at a time; request held by the master until ack.
//   clock, reset        : rising-edge clock, async active-low reset
//   req_read/req_write  : per-channel requests, held until ack
//   req_address/req_data: per-channel address / write data, channel i at [i*W +: W]
//   ack                 : one-cycle completion pulse, one-hot or zero
//   rsp_data            : read data, valid in the ack cycle of a read
//   conflict            : pulse in ACCESS when the winner set read and write together
//   mem_*               : data_memory strobes, address, write data and read data
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE,
  parameter int DATA_SIZE    = DEF_DATA_SIZE,
  parameter int MEM_LATENCY  = DEF_MEM_LATENCY
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [CHANNELS-1:0]              req_read,
  input  logic [CHANNELS-1:0]              req_write,
  input  logic [CHANNELS*ADDRESS_SIZE-1:0] req_address,
  input  logic [CHANNELS*DATA_SIZE-1:0]    req_data,
  output logic [CHANNELS-1:0]              ack,
  output logic [DATA_SIZE-1:0]             rsp_data,
  output logic                             conflict,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDRESS_SIZE-1:0]          mem_address,
  output logic [DATA_SIZE-1:0]             mem_data_out,
  input  logic [DATA_SIZE-1:0]             mem_data_in
);

  localparam int GW = grant_width(CHANNELS);
  localparam logic [3:0] LAT_M1 = 4'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

  arb_state_e state, state_nxt;
  arb_op_t    op;
  logic [GW-1:0] grant, last_grant, win;
  logic          win_vld;
  logic [3:0]    wait_cnt;

  logic [CHANNELS-1:0][ADDRESS_SIZE-1:0] addr_arr;
  logic [CHANNELS-1:0][DATA_SIZE-1:0]    data_arr;
  logic [ADDRESS_SIZE-1:0] sel_addr;
  logic [DATA_SIZE-1:0]    sel_data;
  logic                    sel_rd, sel_wr;

  assign addr_arr = req_address;
  assign data_arr = req_data;

  round_robin_picker #(.CHANNELS(CHANNELS), .GW(GW)) u_picker (
    .req        (req_read | req_write),
    .last_grant (last_grant),
    .winner     (win),
    .valid      (win_vld)
  );

  // Per-channel mux by compare rather than a variable index, so CHANNELS=1
  // does not need a zero-width select.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_rd   = 1'b0;
    sel_wr   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (win == GW'(i)) begin
        sel_addr = addr_arr[i];
        sel_data = data_arr[i];
        sel_rd   = req_read[i];
        sel_wr   = req_write[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    conflict  = 1'b0;
    ack       = '0;
    case (state)
      ARB_IDLE:   if (win_vld) state_nxt = ARB_ACCESS;
      ARB_ACCESS: begin
        mem_read  = ~op.write;
        mem_write = op.write;
        conflict  = op.conflict;
        state_nxt = (op.write || MEM_LATENCY == 0) ? ARB_RESPOND : ARB_WAIT;
      end
      ARB_WAIT:   if (wait_cnt == 4'd0) state_nxt = ARB_RESPOND;
      ARB_RESPOND: begin
        for (int i = 0; i < CHANNELS; i++) ack[i] = (grant == GW'(i));
        state_nxt = ARB_IDLE;
      end
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  // Latch registers, wait counter and read capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant        <= '0;
      last_grant   <= GW'(CHANNELS - 1);
      op           <= '0;
      mem_address  <= '0;
      mem_data_out <= '0;
      wait_cnt     <= '0;
      rsp_data     <= '0;
    end else begin
      case (state)
        ARB_IDLE: if (win_vld) begin
          grant        <= win;
          last_grant   <= win;
          op.write     <= sel_wr;
          op.conflict  <= sel_rd & sel_wr;
          mem_address  <= sel_addr;
          mem_data_out <= sel_data;
        end
        ARB_ACCESS: begin
          wait_cnt <= LAT_M1;
          if (!op.write && MEM_LATENCY == 0) rsp_data <= mem_data_in;
        end
        ARB_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd0) rsp_data <= mem_data_in;
        end
        default: ;
      endcase
    end
  end

endmodule
